mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-stage load/store unit that acts as the initiator toward the word-wide `data_mem` array. It accepts one load or store request per transaction from the EX/MEM pipeline register. It drives the memory's `address`/`in_data`/`MemWrite`/`MemRead` and consumes `out_data`. Byte and halfword accesses use sign/zero extension on loads and read-modify-write on stores, because the array has no byte enables.

## Interface
- `ADDR_W`, 13: byte-address width; the word index is `ADDR_W-2` = 11 bits.
- `DATA_W`, 32: data width; fixed at 32.

- `clock`  in  1  single clock; all state is updated on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when high together with `req_valid`.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 = byte, 01 = half, 10 = word; 11 is illegal and treated as misaligned.
- `req_unsigned`  in  1  1 = zero-extend on loads; ignored on stores.
- `req_addr`  in  13  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `rsp_valid`  out  1  one-cycle pulse marking transaction completion.
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors.
- `rsp_err`  out  1  misaligned or illegal-size request.
- `mem_address`  out  11  drives `data_mem.address` (`req_addr[12:2]`).
- `mem_in_data`  out  32  drives `data_mem.in_data`.
- `mem_write`  out  1  drives `MemWrite`.
- `mem_read`  out  1  drives `MemRead`.
- `mem_rdata`  in  32  from `data_mem.out_data`; valid after the falling edge of a cycle with `mem_read`=1.

## Operation
- **Little-endian byte lanes:** lane k = bits [8k+7:8k], where k = `addr[1:0]`.
- **Request capture:** on acceptance, `addr`, `size`, `unsigned`, `write` and `wdata` are registered. The request is ignored while `req_ready`=0.
- **FSM states:** IDLE, LOAD, RMW_RD, STORE, RESP.
  - **IDLE:** `req_ready`=1. On accept:
    - misaligned request (half with `addr[0]`=1, word with `addr[1:0]`≠0, or size 11) → RESP with err set;
    - load → LOAD;
    - word store → STORE;
    - byte or half store → RMW_RD.
  - **LOAD:** `mem_read`=1. Capture `mem_rdata` at the end of the cycle, extract the lane, extend it → RESP.
  - **RMW_RD:** `mem_read`=1. Capture `mem_rdata` and merge `wdata[7:0]` (byte) or `wdata[15:0]` (half at lane `addr[1]`*2) into it → STORE.
  - **STORE:** `mem_write`=1 and `mem_in_data` = merged word (or `wdata` for a word store); the memory writes at the closing rising edge → RESP.
  - **RESP:** `rsp_valid`=1 for exactly one cycle → IDLE.
- **Control outputs:** `mem_read`/`mem_write` are registered and never high together. Both are 0 in IDLE and RESP.
- **Address stability:** `mem_address` is held stable from the accept edge through RESP.
- **Response data:** `rsp_rdata` and `rsp_err` hold their values until the next RESP. `rsp_rdata` is 0 on stores and errors.
- **Misaligned requests:** no memory access is issued.

## Timing
- **Reset values:** state IDLE; `req_ready`=1; every other output 0, including `mem_address`, `mem_in_data` and `rsp_rdata`.
- **Latency from the accept edge to `rsp_valid`:**
  - load: 2 cycles;
  - word store: 2 cycles;
  - byte/half store: 3 cycles;
  - misaligned: 1 cycle.
- **Throughput:** one transaction at a time. The next accept is possible in the cycle after RESP.
- **Reset mid-operation:**
  - The transaction is aborted.
  - If reset is asserted before the closing edge of STORE, `mem_write` is already 0 at that edge and no write occurs.
  - No `rsp_valid` is issued.
- **Memory timing:** the read path depends on `data_mem` sampling on the falling edge. `mem_rdata` is registered only at the rising edge that ends LOAD/RMW_RD.

## Structure
- **Shared package:** size codes (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`) and the FSM state encoding.
- **Sub-module `mem_lane_align`** (combinational): load extract/extend and store merge, given `addr[1:0]`, size and unsigned.
- **FSM and registers:** live in `mem_access_unit`.

## Test plan
- **Signed byte load:** preload word 4 = 0x8899AABB; lb at 0x013 → `rsp_rdata`=0xFFFFFF88, `rsp_valid` 2 cycles after accept, `mem_address`=4.
- **Halfword loads:** same word; lhu at 0x012 → 0x00008899; lh at 0x012 → 0xFFFF8899; lbu at 0x010 → 0x000000BB.
- **Byte store (RMW):** sb 0x5A at 0x011 → one `mem_read` cycle, then one `mem_write` cycle with `mem_in_data`=0x88995ABB; word 4 = 0x88995ABB; `rsp_valid` 3 cycles after accept.
- **Word store:** sw 0xDEADBEEF at 0x020 → `mem_read` never asserted; word 8 = 0xDEADBEEF; `rsp_valid` 2 cycles after accept, `rsp_rdata`=0.
- **Misaligned load:** lw at 0x012 → `rsp_err`=1 and `rsp_rdata`=0 one cycle after accept; no `mem_read`/`mem_write` pulse.
- **Reset during STORE:** assert `reset` low during the STORE cycle of sw 0x12345678 to word 8 → word 8 unchanged, all outputs at reset values, no `rsp_valid`, `req_ready`=1 after release.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory-stage load/store unit: size codes,
// FSM state encoding and the alignment rule.
package mem_access_unit_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_STORE  = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

  // Size 11 has no legal alignment, so it is folded into the misaligned case.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = lo[0];
      SZ_WORD: mis = (lo != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian byte-lane steering: extract/extend load data and merge
// sub-word store data into the word read back from memory.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = rdata_i[{addr_lo_i, 3'b000} +: 8];
  assign half_v = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];

  always_comb begin
    load_data_o = rdata_i;
    case (size_i)
      SZ_BYTE: load_data_o = unsigned_i ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
      SZ_HALF: load_data_o = unsigned_i ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
      default: load_data_o = rdata_i;
    endcase
  end

  // No byte enables on the array, so sub-word stores overwrite one lane of the old word.
  always_comb begin
    merged_o = rdata_i;
    case (size_i)
      SZ_BYTE: merged_o[{addr_lo_i, 3'b000} +: 8]     = wdata_i[7:0];
      SZ_HALF: merged_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default: merged_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit driving a word-wide data_mem array; one
// transaction at a time, read-modify-write for byte/half stores.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-3:0] mem_address,
  output logic [DATA_W-1:0] mem_in_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] mem_in_q, mem_in_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [31:0] load_data, merged;

  mem_lane_align u_align (
    .addr_lo_i   (addr_q[1:0]),
    .size_i      (size_q),
    .unsigned_i  (uns_q),
    .rdata_i     (mem_rdata),
    .wdata_i     (wdata_q),
    .load_data_o (load_data),
    .merged_o    (merged)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      size_q   <= '0;
      uns_q    <= 1'b0;
      wdata_q  <= '0;
      mem_in_q <= '0;
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      wdata_q  <= wdata_d;
      mem_in_q <= mem_in_d;
      mem_rd_q <= mem_rd_d;
      mem_wr_q <= mem_wr_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Memory strobes are registered: they are set on the transition into the
  // state that owns them, so each is high for exactly that state.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    size_d   = size_q;
    uns_d    = uns_q;
    wdata_d  = wdata_q;
    mem_in_d = mem_in_q;
    mem_rd_d = 1'b0;
    mem_wr_d = 1'b0;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          size_d  = req_size;
          uns_d   = req_unsigned;
          wdata_d = req_wdata;
          if (is_misaligned(req_size, req_addr[1:0])) begin
            state_d = ST_RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end else if (!req_write) begin
            state_d  = ST_LOAD;
            mem_rd_d = 1'b1;
          end else if (req_size == SZ_WORD) begin
            state_d  = ST_STORE;
            mem_wr_d = 1'b1;
            mem_in_d = req_wdata;
          end else begin
            state_d  = ST_RMW_RD;
            mem_rd_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        rdata_d = load_data;
        err_d   = 1'b0;
        state_d = ST_RESP;
      end
      ST_RMW_RD: begin
        mem_in_d = merged;
        mem_wr_d = 1'b1;
        state_d  = ST_STORE;
      end
      ST_STORE: begin
        rdata_d = '0;
        err_d   = 1'b0;
        state_d = ST_RESP;
      end
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign mem_address = addr_q[ADDR_W-1:2];
  assign mem_in_data = mem_in_q;
  assign mem_read    = mem_rd_q;
  assign mem_write   = mem_wr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: behavioural data_mem, directed test-plan steps,
// then randomized transactions against an arithmetic reference model.
module tb_mem_access_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_write, req_unsigned;
  logic        req_ready, rsp_valid, rsp_err, mem_write, mem_read;
  logic [1:0]  req_size;
  logic [12:0] req_addr;
  logic [31:0] req_wdata, rsp_rdata, mem_in_data;
  logic [31:0] mem_rdata = '0;
  logic [10:0] mem_address;

  logic [31:0] mem     [0:2047];
  logic [31:0] ref_mem [0:2047];

  int n_pass = 0, n_fail = 0, n_total = 0;
  logic [31:0] last_rd, last_in;

  always #5 clock = ~clock;

  mem_access_unit #(.ADDR_W(13), .DATA_W(32)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_address(mem_address), .mem_in_data(mem_in_data),
    .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'h8899AABB : ((32'h9E3779B9 * 32'(i)) ^ 32'h5A5AA5A5);
  endfunction

  // data_mem: falling-edge read, rising-edge write
  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = init_word(i);
    forever begin
      @(posedge clock);
      if (mem_write === 1'b1) mem[mem_address] = mem_in_data;
    end
  end

  always @(negedge clock) if (mem_read === 1'b1) mem_rdata <= mem[mem_address];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic xact(input logic w, input logic [1:0] sz, input logic u,
                      input logic [12:0] a, input logic [31:0] wd, input string tag);
    logic        mis, addr_ok, both, got_err;
    int          exp_lat, lat, nr, nw, exp_nr, exp_nw, sh;
    logic [31:0] word, v, mask, exp_rd, exp_in, got_rd, got_in;
    logic [10:0] idx;
    idx  = a[12:2];
    sh   = 8 * int'(a[1:0]);
    word = ref_mem[idx];
    mis  = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    mask = (sz == 2'b00) ? 32'h000000FF : (sz == 2'b01) ? 32'h0000FFFF : 32'hFFFFFFFF;
    v    = (word >> sh) & mask;
    exp_rd = 32'h0;
    exp_in = (word & ~(mask << sh)) | ((wd & mask) << sh);
    if (!mis && !w) begin
      if (sz == 2'b00)      exp_rd = (u || !v[7])  ? v : (v | 32'hFFFFFF00);
      else if (sz == 2'b01) exp_rd = (u || !v[15]) ? v : (v | 32'hFFFF0000);
      else                  exp_rd = v;
    end
    exp_lat = mis ? 1 : (!w ? 2 : (sz == 2'b10 ? 2 : 3));
    exp_nr  = (!mis && (!w || sz != 2'b10)) ? 1 : 0;
    exp_nw  = (!mis && w) ? 1 : 0;

    @(negedge clock);
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = wd;
    @(posedge clock); #1;
    req_valid = 1'b0; req_wdata = $urandom;
    lat = 0; nr = 0; nw = 0; addr_ok = 1'b1; both = 1'b0;
    got_in = 32'h0; got_rd = 32'hX; got_err = 1'bX;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) begin @(posedge clock); #1; end
      if (mem_read === 1'b1) nr++;
      if (mem_write === 1'b1) begin nw++; got_in = mem_in_data; end
      if (mem_read === 1'b1 && mem_write === 1'b1) both = 1'b1;
      if (mem_address !== idx) addr_ok = 1'b0;
      if (rsp_valid === 1'b1) begin
        lat = k; got_rd = rsp_rdata; got_err = rsp_err;
        break;
      end
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_rdata"}, got_rd, exp_rd);
    chk({tag, "_err"}, 32'(got_err), 32'(mis));
    chk({tag, "_nread"}, 32'(nr), 32'(exp_nr));
    chk({tag, "_nwrite"}, 32'(nw), 32'(exp_nw));
    chk({tag, "_addr_stable"}, 32'(addr_ok), 32'd1);
    chk({tag, "_rd_wr_excl"}, 32'(both), 32'd0);
    if (!mis && w) begin
      chk({tag, "_in_data"}, got_in, exp_in);
      ref_mem[idx] = exp_in;
    end
    chk({tag, "_mem_word"}, mem[idx], ref_mem[idx]);
    last_rd = got_rd;
    last_in = got_in;
    @(posedge clock); #1;
    chk({tag, "_rsp_pulse"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rdata_hold"}, rsp_rdata, exp_rd);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) ref_mem[i] = init_word(i);
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_mem_address", 32'(mem_address), 32'd0);
    chk("rst_mem_in_data", mem_in_data, 32'h0);
    chk("rst_mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
    @(negedge clock) reset = 1'b1;

    // test-plan directed steps
    xact(1'b0, 2'b00, 1'b0, 13'h013, 32'h0, "lb_013");
    chk("plan_lb_value", last_rd, 32'hFFFFFF88);
    xact(1'b0, 2'b01, 1'b1, 13'h012, 32'h0, "lhu_012");
    chk("plan_lhu_value", last_rd, 32'h00008899);
    xact(1'b0, 2'b01, 1'b0, 13'h012, 32'h0, "lh_012");
    chk("plan_lh_value", last_rd, 32'hFFFF8899);
    xact(1'b0, 2'b00, 1'b1, 13'h010, 32'h0, "lbu_010");
    chk("plan_lbu_value", last_rd, 32'h000000BB);
    xact(1'b1, 2'b00, 1'b0, 13'h011, 32'h0000005A, "sb_011");
    chk("plan_sb_in_data", last_in, 32'h88995ABB);
    chk("plan_sb_word4", mem[4], 32'h88995ABB);
    xact(1'b1, 2'b10, 1'b0, 13'h020, 32'hDEADBEEF, "sw_020");
    chk("plan_sw_word8", mem[8], 32'hDEADBEEF);
    xact(1'b0, 2'b10, 1'b0, 13'h012, 32'h0, "lw_mis_012");
    xact(1'b1, 2'b11, 1'b0, 13'h014, 32'h11223344, "size11_st");

    // reset asserted during STORE of sw to word 8
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 13'h020; req_wdata = 32'h12345678;
    @(posedge clock); #1;
    req_valid = 1'b0;
    chk("rststore_in_store", 32'(mem_write), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("rststore_ready", 32'(req_ready), 32'd1);
    chk("rststore_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rststore_outputs", {20'd0, mem_address, mem_read}, 32'd0);
    chk("rststore_mem_write", 32'(mem_write), 32'd0);
    chk("rststore_in_data", mem_in_data, 32'h0);
    chk("rststore_rsp_rdata", rsp_rdata, 32'h0);
    chk("rststore_rsp_err", 32'(rsp_err), 32'd0);
    @(posedge clock);
    @(negedge clock) reset = 1'b1;
    begin
      int saw_rsp;
      saw_rsp = 0;
      for (int k = 0; k < 4; k++) begin
        @(posedge clock); #1;
        if (rsp_valid === 1'b1) saw_rsp++;
      end
      chk("rststore_no_rsp", 32'(saw_rsp), 32'd0);
    end
    chk("rststore_word8", mem[8], 32'hDEADBEEF);
    chk("rststore_ready_after", 32'(req_ready), 32'd1);

    // randomized transactions over a small window so words get reused
    for (int t = 0; t < 60; t++) begin
      logic [12:0] ra;
      ra = 13'($urandom_range(0, 63));
      xact(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), ra, $urandom,
           $sformatf("rnd%0d", t));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
